// File: rtl/orion_icache.sv
// orion_icache: blocking, direct-mapped instruction cache.
//
// A fetch is accepted in IDLE and looked up in the following cycle.
// A hit responds in that lookup cycle. A miss refills the whole line,
// one word at a time and in order from word 0, over the mem_* port.
// The requested word is then returned in a separate RESPOND cycle.
//
// Ports:
//   clk_i, rst_i        clock; asynchronous active-low reset
//   imem_addr_i         fetch address (bits [1:0] ignored)
//   imem_valid_i        fetch request, held until imem_resp_o
//   imem_rdata_o        fetched word, non-zero only while imem_resp_o=1
//   imem_resp_o         one-cycle response pulse
//   flush_i             invalidate all lines (fence.i)
//   mem_addr_o          refill word address
//   mem_valid_o         refill request
//   mem_rdata_i         refill data, sampled with mem_resp_i
//   mem_resp_i          refill word complete
//   perf_hits_o         lookup hit counter
//   perf_misses_o       lookup miss counter
//
// Optional feature: define ORION_ICACHE_PERF_EN to build the two
// 32-bit performance counters. Without it both outputs are tied to 0.
module orion_icache #(
  parameter int XLEN       = 32,
  parameter int ADDRW      = 32,
  parameter int NUM_LINES  = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [ADDRW-1:0] imem_addr_i,
  input  logic             imem_valid_i,
  output logic [XLEN-1:0]  imem_rdata_o,
  output logic             imem_resp_o,
  input  logic             flush_i,
  output logic [ADDRW-1:0] mem_addr_o,
  output logic             mem_valid_o,
  input  logic [XLEN-1:0]  mem_rdata_i,
  input  logic             mem_resp_i,
  output logic [31:0]      perf_hits_o,
  output logic [31:0]      perf_misses_o
);
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDRW - IDX_W - OFF_W - 2;

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_REFILL, S_RESPOND} state_e;

  state_e                 state_q, state_d;
  logic [OFF_W-1:0]       k_q, k_d;
  logic [ADDRW-3:0]       req_q, req_d;     // word address of the fetch
  logic [NUM_LINES-1:0]   valid_q, valid_d;
  logic                   pend_q, pend_d;   // flush seen mid-transaction

  logic [TAG_W-1:0]       tag_q  [NUM_LINES];
  logic [XLEN-1:0]        data_q [NUM_LINES*LINE_WORDS];

  logic [TAG_W-1:0]       req_tag;
  logic [IDX_W-1:0]       req_idx;
  logic [OFF_W-1:0]       req_off;
  logic                   hit;
  logic                   last_beat;
  logic                   resp;
  logic                   eot;

  // Byte-offset bits of the fetch address carry no information.
  logic                   unused_addr_bits;
  assign unused_addr_bits = ^imem_addr_i[1:0];

  assign req_off   = req_q[OFF_W-1:0];
  assign req_idx   = req_q[OFF_W +: IDX_W];
  assign req_tag   = req_q[ADDRW-3 -: TAG_W];
  assign hit       = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign last_beat = (state_q == S_REFILL) && mem_resp_i &&
                     (k_q == OFF_W'(LINE_WORDS - 1));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      req_q   <= '0;
      valid_q <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    req_d   = req_q;
    valid_d = valid_q;
    pend_d  = pend_q;
    resp    = 1'b0;
    eot     = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Clearing here means a request accepted alongside the flush
        // looks up against the emptied array and misses.
        if (flush_i) valid_d = '0;
        if (imem_valid_i) begin
          req_d   = imem_addr_i[ADDRW-1:2];
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (hit) begin
          resp    = 1'b1;
          eot     = 1'b1;
          state_d = S_IDLE;
        end else begin
          k_d     = '0;
          state_d = S_REFILL;
        end
      end
      S_REFILL: begin
        if (mem_resp_i) begin
          k_d = k_q + 1'b1;
          if (last_beat) begin
            valid_d[req_idx] = !(pend_q || flush_i);
            state_d          = S_RESPOND;
          end
        end
      end
      S_RESPOND: begin
        resp    = 1'b1;
        eot     = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A flush arriving mid-transaction is deferred to its final cycle so
    // the refill in flight completes and the core still gets its word.
    if (state_q != S_IDLE) begin
      if (eot) begin
        if (pend_q || flush_i) valid_d = '0;
        pend_d = 1'b0;
      end else if (flush_i) begin
        pend_d = 1'b1;
      end
    end
  end

  // Tag and data arrays carry no reset.
  always_ff @(posedge clk_i) begin
    if ((state_q == S_REFILL) && mem_resp_i)
      data_q[{req_idx, k_q}] <= mem_rdata_i;
    if (last_beat)
      tag_q[req_idx] <= req_tag;
  end

  assign imem_resp_o  = resp;
  assign imem_rdata_o = resp ? data_q[{req_idx, req_off}] : '0;
  assign mem_valid_o  = (state_q == S_REFILL);
  assign mem_addr_o   = (state_q == S_REFILL) ?
                        {req_q[ADDRW-3:OFF_W], k_q, 2'b00} : '0;

`ifdef ORION_ICACHE_PERF_EN
  logic [31:0] hits_q, misses_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      hits_q   <= '0;
      misses_q <= '0;
    end else if (state_q == S_LOOKUP) begin
      if (hit) hits_q   <= hits_q + 32'd1;
      else     misses_q <= misses_q + 32'd1;
    end
  end

  assign perf_hits_o   = hits_q;
  assign perf_misses_o = misses_q;
`else
  assign perf_hits_o   = '0;
  assign perf_misses_o = '0;
`endif

endmodule

// File: tb/tb_orion_icache.sv
// Scoreboard bench for orion_icache (default parameters).
module tb_orion_icache;
  localparam int LW = 4;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [31:0] imem_addr_i = '0;
  logic        imem_valid_i = 1'b0;
  logic [31:0] imem_rdata_o;
  logic        imem_resp_o;
  logic        flush_i = 1'b0;
  logic [31:0] mem_addr_o;
  logic        mem_valid_o;
  logic [31:0] mem_rdata_i;
  logic        mem_resp_i;
  logic [31:0] perf_hits_o;
  logic [31:0] perf_misses_o;

  orion_icache dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .imem_addr_i  (imem_addr_i),
    .imem_valid_i (imem_valid_i),
    .imem_rdata_o (imem_rdata_o),
    .imem_resp_o  (imem_resp_o),
    .flush_i      (flush_i),
    .mem_addr_o   (mem_addr_o),
    .mem_valid_o  (mem_valid_o),
    .mem_rdata_i  (mem_rdata_i),
    .mem_resp_i   (mem_resp_i),
    .perf_hits_o  (perf_hits_o),
    .perf_misses_o(perf_misses_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    bit          hit;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] exp_mem[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int req_cyc = 0;
  int wait_cnt = 0;
  int lat_cfg = 0;
  bit saw_mem = 1'b0;

  // Reference cache contents and lookup counts
  bit [15:0]   m_valid = '0;
  bit [23:0]   m_tag [16];
  logic [31:0] m_hits = '0;
  logic [31:0] m_misses = '0;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Backing memory: responds after lat_cfg wait cycles per word.
  assign mem_resp_i  = mem_valid_o && (wait_cnt >= lat_cfg);
  assign mem_rdata_i = mem_valid_o ? mem_model(mem_addr_o) : '0;

  always @(posedge clk_i) begin
    cyc <= cyc + 1;
    if (mem_valid_o && !mem_resp_i) wait_cnt <= wait_cnt + 1;
    else                            wait_cnt <= 0;
  end

  // Monitor: refill addresses and core responses against the scoreboard.
  always @(negedge clk_i) begin
    exp_t        e;
    logic [31:0] ea;
    if (mem_valid_o) saw_mem = 1'b1;
    if (mem_valid_o && mem_resp_i) begin
      if (exp_mem.size() == 0) chk("refill_unexp", exp_mem.size(), 1);
      else begin
        ea = exp_mem.pop_front();
        chk("maddr", mem_addr_o, ea);
      end
    end
    if (imem_resp_o) begin
      if (sb.size() == 0) chk("resp_unexp", sb.size(), 1);
      else begin
        e = sb.pop_front();
        chk("rdata", imem_rdata_o, e.data);
        chk("was_hit", {31'b0, !saw_mem}, {31'b0, e.hit});
        chk("latency", cyc - req_cyc, e.lat);
      end
    end
  end

  task automatic perf_check();
`ifdef ORION_ICACHE_PERF_EN
    chk("perf_hits", perf_hits_o, m_hits);
    chk("perf_misses", perf_misses_o, m_misses);
`else
    chk("perf_hits", perf_hits_o, 32'd0);
    chk("perf_misses", perf_misses_o, 32'd0);
`endif
  endtask

  task automatic do_flush();
    @(negedge clk_i);
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    m_valid = '0;
  endtask

  // fl_mode: 0 none, 1 flush in the accepting cycle, 2 flush during refill
  task automatic fetch(input logic [31:0] a, input int fl_mode);
    int        idx;
    bit [23:0] tg;
    bit        h;
    bit        got;
    bit        fl_done;
    exp_t      e;
    idx     = int'(a[7:4]);
    tg      = a[31:8];
    got     = 1'b0;
    fl_done = 1'b0;
    @(negedge clk_i);
    if (fl_mode == 1) begin
      flush_i = 1'b1;
      m_valid = '0;
    end
    h = m_valid[idx] && (m_tag[idx] == tg);
    if (h) m_hits++;
    else begin
      m_misses++;
      for (int w = 0; w < LW; w++)
        exp_mem.push_back({a[31:4], 4'b0000} + 32'(w * 4));
    end
    e.addr = a;
    e.data = mem_model({a[31:2], 2'b00});
    e.hit  = h;
    e.lat  = h ? 1 : 2 + LW * (lat_cfg + 1);
    sb.push_back(e);
    saw_mem      = 1'b0;
    req_cyc      = cyc;
    imem_addr_i  = a;
    imem_valid_i = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk_i);
      flush_i = 1'b0;
      if (fl_mode == 2 && mem_valid_o && !fl_done) begin
        flush_i = 1'b1;
        fl_done = 1'b1;
      end
      if (imem_resp_o) got = 1'b1;
    end
    if (!got) chk("resp_timeout", {31'b0, got}, 32'd1);
    @(posedge clk_i);
    #1;
    imem_valid_i = 1'b0;
    flush_i      = 1'b0;
    if (!h) begin
      if (fl_mode == 2) m_valid = '0;
      else begin
        m_valid[idx] = 1'b1;
        m_tag[idx]   = tg;
      end
    end
  endtask

  initial begin
    logic [31:0] base;
    bit          started;

    // Reset state
    repeat (2) @(negedge clk_i);
    chk("rst_resp", {31'b0, imem_resp_o}, 32'd0);
    chk("rst_mvalid", {31'b0, mem_valid_o}, 32'd0);
    chk("rst_maddr", mem_addr_o, 32'd0);
    chk("rst_rdata", imem_rdata_o, 32'd0);
    perf_check();
    @(negedge clk_i);
    rst_i = 1'b1;

    // Cold miss, zero-wait memory; then hits in the same line
    lat_cfg = 0;
    fetch(32'h0000_0104, 0);
    fetch(32'h0000_0108, 0);
    fetch(32'h0000_0100, 0);
    fetch(32'h0000_010C, 0);

    // Conflict misses on index 0
    fetch(32'h0000_0500, 0);
    fetch(32'h0000_0100, 0);
    fetch(32'h0000_0500, 0);
    fetch(32'h0000_0200, 0);
    fetch(32'h0000_0204, 0);
    perf_check();

    // Flush in IDLE: everything misses afterwards
    do_flush();
    fetch(32'h0000_0104, 0);
    fetch(32'h0000_0204, 0);
    fetch(32'h0000_0104, 0);

    // Flush during a refill with wait states
    lat_cfg = 2;
    fetch(32'h0000_0300, 2);
    fetch(32'h0000_0300, 0);
    fetch(32'h0000_0104, 0);
    fetch(32'h0000_0304, 0);

    // Flush in the same cycle as the request is accepted
    lat_cfg = 0;
    fetch(32'h0000_0308, 1);
    fetch(32'h0000_030C, 0);
    perf_check();

    // Mixed traffic over a few conflicting lines
    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 3))
        0:       base = 32'h0000_0100;
        1:       base = 32'h0000_0500;
        2:       base = 32'h0000_0900;
        default: base = 32'h0000_0210;
      endcase
      lat_cfg = int'($urandom_range(0, 2));
      fetch(base + 32'($urandom_range(0, 3) * 4), 0);
    end
    perf_check();

    // Asynchronous reset in the middle of a refill
    lat_cfg = 3;
    @(negedge clk_i);
    for (int w = 0; w < LW; w++) exp_mem.push_back(32'h0000_0700 + 32'(w * 4));
    imem_addr_i  = 32'h0000_0700;
    imem_valid_i = 1'b1;
    started      = 1'b0;
    for (int i = 0; i < 20 && !started; i++) begin
      @(negedge clk_i);
      if (mem_valid_o) started = 1'b1;
    end
    chk("refill_start", {31'b0, started}, 32'd1);
    @(posedge clk_i);
    #2;
    rst_i = 1'b0;
    #1;
    chk("arst_mvalid", {31'b0, mem_valid_o}, 32'd0);
    chk("arst_maddr", mem_addr_o, 32'd0);
    chk("arst_resp", {31'b0, imem_resp_o}, 32'd0);
    imem_valid_i = 1'b0;
    exp_mem.delete();
    m_valid  = '0;
    m_hits   = '0;
    m_misses = '0;
    repeat (2) @(negedge clk_i);
    perf_check();
    rst_i = 1'b1;

    // Cache is empty after release
    lat_cfg = 1;
    fetch(32'h0000_030C, 0);
    fetch(32'h0000_0700, 0);
    fetch(32'h0000_0704, 0);
    perf_check();

    repeat (3) @(negedge clk_i);
    chk("sb_drain", sb.size(), 0);
    chk("mem_drain", exp_mem.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/orion_icache.md
Name: orion_icache

Overview:
- Blocking, direct-mapped instruction cache between the core fetch port (imem_*) and the backing instruction memory bus (mem_*).
- Serves hits with one-cycle latency.
- On a miss, refills a whole line one word at a time, then responds to the core.
- flush_i (fence.i) invalidates all lines.

Parameters:
XLEN, 32, data word width in bits
ADDRW, 32, address width in bits
NUM_LINES, 16, number of cache lines; power of two, >= 2
LINE_WORDS, 4, words per line; power of two, >= 2

Ports:
clk_i  in  1  clock; all state on rising edge
rst_i  in  1  asynchronous, active-low reset
imem_addr_i  in  ADDRW  fetch address from core; bits [1:0] ignored
imem_valid_i  in  1  fetch request; core holds it and imem_addr_i stable until imem_resp_o
imem_rdata_o  out  XLEN  fetched instruction; valid only while imem_resp_o=1
imem_resp_o  out  1  one-cycle response pulse
flush_i  in  1  invalidate all lines
mem_addr_o  out  ADDRW  refill word address, word-aligned
mem_valid_o  out  1  refill request; held with stable mem_addr_o until mem_resp_i
mem_rdata_i  in  XLEN  refill data; sampled when mem_resp_i=1
mem_resp_i  in  1  refill word complete; may assert in the same cycle as mem_valid_o
perf_hits_o  out  32  hit counter (see Optional Feature)
perf_misses_o  out  32  miss counter (see Optional Feature)

Behaviour:
- Address split:
  - OFF = log2(LINE_WORDS) word-offset bits at [OFF+1:2].
  - IDX = log2(NUM_LINES) index bits above OFF.
  - Tag is the remaining upper bits.
- Storage:
  - Valid bits, one per line, are reset.
  - Tag and data arrays are not reset.
- Reset (async, rst_i=0):
  - state=IDLE; all valid bits and the pending-flush flag cleared.
  - imem_resp_o=0, mem_valid_o=0, mem_addr_o=0, imem_rdata_o=0, perf counters=0.
  - Reset mid-refill drops the refill immediately; mem_valid_o falls asynchronously.
- State machine:
  - IDLE:
    - If imem_valid_i=1, register the address and go to LOOKUP.
    - If flush_i=1, clear all valid bits this cycle. Flush has priority: a request accepted in the same cycle then looks up against the cleared array (miss).
  - LOOKUP:
    - Compare the registered tag against the tag array at the registered index.
    - Hit (valid and tag equal): imem_resp_o=1, imem_rdata_o = data[idx][off], next state IDLE. Hit latency is 1 cycle after acceptance.
    - Miss: go to REFILL with word counter k=0.
  - REFILL:
    - mem_valid_o=1, mem_addr_o = {tag, idx, k, 2'b00}.
    - On mem_resp_i: write mem_rdata_i into data[idx][k], then k++.
    - After the response with k=LINE_WORDS-1: write the tag; set the valid bit unless a flush is pending; go to RESPOND.
    - mem_valid_o drops in the cycle after the last mem_resp_i.
  - RESPOND:
    - imem_resp_o=1 with the requested word, read from the refill buffer/array. Next state IDLE.
- Refill order: always words 0..LINE_WORDS-1 of the line, in order (no critical-word-first).
- Back-to-back: a new request may be accepted in IDLE in the cycle after imem_resp_o. Peak throughput is one fetch per 2 cycles.
- flush_i outside IDLE:
  - Sets a pending-flush flag.
  - At the end of the current transaction (the LOOKUP hit cycle, or the RESPOND cycle) all valid bits are cleared and the flag is cleared.
  - The in-flight bus refill is never aborted. The refilled line is not validated. The core still receives its word.
- imem_valid_i dropping before imem_resp_o is illegal; behaviour is unspecified.
- k counter width: OFF bits; wraps to 0 after the last word.

Optional Feature:
- Macro: ORION_ICACHE_PERF_EN.
- Defined:
  - perf_hits_o increments on each LOOKUP hit; perf_misses_o increments on each LOOKUP miss.
  - Both are 32-bit and wrap at 2^32-1 -> 0.
  - Both reset to 0.
- Undefined: perf_hits_o and perf_misses_o are tied to 0 and no counter flops exist.

Test Plan:
- Cold miss, zero-wait memory (mem_resp_i=mem_valid_o):
  - Stimulus: request 0x0000_0104 accepted at cycle t.
  - Required: mem_addr_o = 0x100, 0x104, 0x108, 0x10C at t+2..t+5; imem_resp_o at t+6 with the word for 0x104.
- Hit after fill:
  - Stimulus: request 0x0000_0108 accepted at cycle u.
  - Required: imem_resp_o at u+1 with the 0x108 data; mem_valid_o stays 0 throughout.
- Conflict miss:
  - Stimulus: with 16 lines x 4 words, fetch 0x100 then 0x500 (same index, different tag).
  - Required: second fetch refills 0x500-0x50C; a following fetch of 0x100 misses again.
- Flush:
  - Stimulus: assert flush_i in IDLE, then refetch 0x104; separately, assert flush_i during REFILL.
  - Required, IDLE case: the refetch of 0x104 misses.
  - Required, REFILL case: the core receives correct data and the next fetch of the same address misses.
- Async reset mid-refill:
  - Stimulus: drive rst_i=0 with mem_valid_o=1.
  - Required: mem_valid_o=0 immediately and the cache is empty after release.
- Perf (ORION_ICACHE_PERF_EN defined):
  - Stimulus: the sequence above.
  - Required: perf_misses_o and perf_hits_o match the scoreboard counts; both read 0 when the macro is undefined.
